// File: rtl/timer_array_if.sv
// Register-window bus between the address bridge and the timer array.
interface timer_array_if;
    logic [29:0] Addr;
    logic        WE;
    logic [3:0]  byteen;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (
        output Addr,
        output WE,
        output byteen,
        output Din,
        input  Dout
    );

    modport slave (
        input  Addr,
        input  WE,
        input  byteen,
        input  Din,
        output Dout
    );
endinterface

// File: rtl/timer_array.sv
// Array of independent down-counting interval timers behind one register window.
// Each channel: CTRL (EN/MODE/IM), PRESET, COUNT (ro), STATUS (W1C pending + state code).
module timer_array #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    timer_array_if.slave      bus,
    output logic [NUM_CH-1:0] IRQ,
    output logic              irq_any
);

    localparam int unsigned CB = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    logic [1:0]               reg_sel;
    logic [CB-1:0]            ch_sel;
    logic [NUM_CH-1:0][31:0]  rd_word;
    logic                     unused_bus;

    // Address decode: 4 registers per channel, higher address bits ignored
    assign reg_sel = bus.Addr[1:0];
    assign ch_sel  = bus.Addr[1+CB:2];

    // Bits of the bus that only some parameterisations consume
    assign unused_bus = ^{bus.Addr[29:2+CB], bus.Din[31:4], bus.byteen[3:1]};

    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic             en_q;
        logic [1:0]       mode_q;
        logic             im_q;
        logic [CNT_W-1:0] preset_q;
        logic [CNT_W-1:0] count_q;
        logic             pending_q;
        logic             sel;
        logic             wr_ctrl;
        logic             wr_preset;
        logic             wr_status;
        logic             auto_reload;
        logic             load_c;
        logic             dec_c;
        logic             set_pend_c;
        logic             clr_en_c;
        logic [CNT_W-1:0] preset_wdata;
        logic [31:0]      rd_c;

        assign sel         = bus.WE && (ch_sel == CB'(i));
        assign wr_ctrl     = sel && (reg_sel == 2'd0) && bus.byteen[0];
        assign wr_preset   = sel && (reg_sel == 2'd1);
        assign wr_status   = sel && (reg_sel == 2'd3) && bus.byteen[0] && bus.Din[0];
        assign auto_reload = (mode_q == 2'b01);

        // Byte-enable merge of write data into PRESET; bits above CNT_W drop out
        always_comb begin
            preset_wdata = preset_q;
            for (int b = 0; b < int'(CNT_W); b++) begin
                if (bus.byteen[b / 8]) begin
                    preset_wdata[b] = bus.Din[b];
                end
            end
        end

        // FSM state register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // FSM next state; a cleared EN forces IDLE from any state
        always_comb begin
            state_d = state_q;
            if (!en_q) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_d = ST_LOAD;
                    ST_LOAD: state_d = ST_CNT;
                    ST_CNT:  if (count_q == '0) state_d = ST_INT;
                    ST_INT:  state_d = auto_reload ? ST_LOAD : ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // FSM outputs; pending is raised on the edge that enters INT
        always_comb begin
            load_c     = 1'b0;
            dec_c      = 1'b0;
            set_pend_c = 1'b0;
            clr_en_c   = 1'b0;
            if (en_q) begin
                case (state_q)
                    ST_LOAD: load_c = 1'b1;
                    ST_CNT: begin
                        if (count_q == '0) begin
                            set_pend_c = 1'b1;
                        end else begin
                            dec_c = 1'b1;
                        end
                    end
                    ST_INT:  clr_en_c = !auto_reload;
                    default: ;
                endcase
            end
        end

        // Register file and counter; a new INT beats a same-cycle W1C
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                en_q      <= 1'b0;
                mode_q    <= 2'b00;
                im_q      <= 1'b0;
                preset_q  <= '0;
                count_q   <= '0;
                pending_q <= 1'b0;
            end else begin
                if (wr_ctrl) begin
                    {im_q, mode_q, en_q} <= bus.Din[3:0];
                end else if (clr_en_c) begin
                    en_q <= 1'b0;
                end
                if (wr_preset) begin
                    preset_q <= preset_wdata;
                end
                if (load_c) begin
                    count_q <= preset_q;
                end else if (dec_c) begin
                    count_q <= count_q - CNT_W'(1);
                end
                if (set_pend_c) begin
                    pending_q <= 1'b1;
                end else if (wr_status) begin
                    pending_q <= 1'b0;
                end
            end
        end

        // Read word for this channel
        always_comb begin
            rd_c = '0;
            case (reg_sel)
                2'd0: rd_c[3:0]       = {im_q, mode_q, en_q};
                2'd1: rd_c[CNT_W-1:0] = preset_q;
                2'd2: rd_c[CNT_W-1:0] = count_q;
                default: rd_c[3:0]    = {state_q, 1'b0, pending_q};
            endcase
        end

        assign rd_word[i] = rd_c;
        assign IRQ[i]     = pending_q & im_q;
    end

    // Combinational read mux; nonexistent channels read zero
    assign bus.Dout = (32'(ch_sel) < NUM_CH) ? rd_word[ch_sel] : 32'h0;

    assign irq_any = |IRQ;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: default (2x32), 4x8 and 3x16 instances.
module tb_timer_array;

    logic       clk;
    logic       reset;
    logic [1:0] irq_a;
    logic [3:0] irq_b;
    logic [2:0] irq_c;
    logic       any_a;
    logic       any_b;
    logic       any_c;
    int         n_chk;
    int         n_pass;

    timer_array_if if_a ();
    timer_array_if if_b ();
    timer_array_if if_c ();

    timer_array #(.NUM_CH(2), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a), .IRQ(irq_a), .irq_any(any_a)
    );
    timer_array #(.NUM_CH(4), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b), .IRQ(irq_b), .irq_any(any_b)
    );
    timer_array #(.NUM_CH(3), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c), .IRQ(irq_c), .irq_any(any_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One register write, landing on the next rising edge
    task automatic wr(input int which, input int ch, input int r,
                      input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        case (which)
            0: begin if_a.Addr = 30'(ch * 4 + r); if_a.Din = d; if_a.byteen = be; if_a.WE = 1'b1; end
            1: begin if_b.Addr = 30'(ch * 4 + r); if_b.Din = d; if_b.byteen = be; if_b.WE = 1'b1; end
            default: begin if_c.Addr = 30'(ch * 4 + r); if_c.Din = d; if_c.byteen = be; if_c.WE = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if_a.WE = 1'b0;
        if_b.WE = 1'b0;
        if_c.WE = 1'b0;
    endtask

    // Combinational read and compare, 1 ns per access
    task automatic rchk(input string tag, input int which, input int ch, input int r,
                        input logic [31:0] exp);
        logic [31:0] d;
        case (which)
            0: if_a.Addr = 30'(ch * 4 + r);
            1: if_b.Addr = 30'(ch * 4 + r);
            default: if_c.Addr = 30'(ch * 4 + r);
        endcase
        #1;
        case (which)
            0: d = if_a.Dout;
            1: d = if_b.Dout;
            default: d = if_c.Dout;
        endcase
        chk(tag, d, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        if_a.Addr = '0; if_a.WE = 1'b0; if_a.byteen = '0; if_a.Din = '0;
        if_b.Addr = '0; if_b.WE = 1'b0; if_b.byteen = '0; if_b.Din = '0;
        if_c.Addr = '0; if_c.WE = 1'b0; if_c.byteen = '0; if_c.Din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Post-reset state
        rchk("rst_status", 0, 0, 3, 32'h0);
        rchk("rst_ctrl", 0, 1, 0, 32'h0);
        chk("rst_irq", 32'(irq_a), 32'h0);

        // One-shot, PRESET=5: IRQ after E+8
        wr(0, 0, 1, 32'd5, 4'hF);
        wr(0, 0, 0, 32'h9, 4'hF);
        cycles(7);
        chk("os_irq_early", 32'(irq_a), 32'h0);
        rchk("os_count_zero", 0, 0, 2, 32'h0);
        rchk("os_status_cnt", 0, 0, 3, 32'h8);
        cycles(1);
        chk("os_irq", 32'(irq_a), 32'h1);
        chk("os_any", 32'(any_a), 32'h1);
        rchk("os_status_int", 0, 0, 3, 32'hD);
        cycles(1);
        rchk("os_ctrl_en_clr", 0, 0, 0, 32'h8);
        rchk("os_status_idle", 0, 0, 3, 32'h1);
        wr(0, 0, 3, 32'h1, 4'hF);
        chk("os_w1c_irq", 32'(irq_a), 32'h0);
        rchk("os_w1c_status", 0, 0, 3, 32'h0);

        // Auto-reload ch1, PRESET=3: period 6
        wr(0, 1, 1, 32'd3, 4'hF);
        wr(0, 1, 0, 32'hB, 4'hF);
        cycles(5);
        chk("ar_irq_early", 32'(irq_a), 32'h0);
        cycles(1);
        chk("ar_irq_first", 32'(irq_a), 32'h2);
        wr(0, 1, 3, 32'h1, 4'hF);
        chk("ar_w1c", 32'(irq_a), 32'h0);
        cycles(4);
        chk("ar_irq_gap", 32'(irq_a), 32'h0);
        cycles(1);
        chk("ar_irq_second", 32'(irq_a), 32'h2);

        // Mask hides pending; W1C racing a new INT loses
        wr(0, 1, 0, 32'h3, 4'hF);
        chk("mask_irq", 32'(irq_a), 32'h0);
        chk("mask_any", 32'(any_a), 32'h0);
        rchk("mask_pending", 0, 1, 3, 32'h5);
        cycles(4);
        wr(0, 1, 3, 32'h1, 4'hF);
        rchk("race_set_wins", 0, 1, 3, 32'hD);
        wr(0, 1, 3, 32'h1, 4'hF);
        rchk("w1c_after", 0, 1, 3, 32'h4);
        wr(0, 1, 0, 32'h0, 4'hF);

        // Byte enables, ignored writes, aliasing of high channel bits
        wr(0, 0, 1, 32'h11223344, 4'hF);
        wr(0, 0, 1, 32'hAABBCCDD, 4'b0011);
        rchk("be_preset", 0, 0, 1, 32'h1122CCDD);
        wr(0, 0, 2, 32'h55, 4'hF);
        rchk("count_ro", 0, 0, 2, 32'h0);
        wr(0, 2, 1, 32'h77, 4'hF);
        rchk("alias_ch0", 0, 0, 1, 32'h77);
        rchk("alias_ch1_kept", 0, 1, 1, 32'h3);
        wr(0, 0, 0, 32'hFFFFFFF6, 4'hF);
        rchk("ctrl_undef", 0, 0, 0, 32'h6);

        // Pause and resume ch0, PRESET=10
        wr(0, 0, 1, 32'd10, 4'hF);
        wr(0, 0, 0, 32'h1, 4'hF);
        cycles(5);
        rchk("run_count", 0, 0, 2, 32'd7);
        wr(0, 0, 0, 32'h0, 4'hF);
        cycles(3);
        rchk("pause_count", 0, 0, 2, 32'd6);
        rchk("pause_status", 0, 0, 3, 32'h0);
        wr(0, 0, 0, 32'h1, 4'hF);
        cycles(1);
        rchk("resume_load", 0, 0, 3, 32'h4);
        rchk("resume_hold", 0, 0, 2, 32'd6);
        cycles(1);
        rchk("resume_reload", 0, 0, 2, 32'd10);
        wr(0, 0, 1, 32'd2, 4'hF);
        cycles(1);
        rchk("preset_mid_cnt", 0, 0, 2, 32'd8);
        wr(0, 0, 0, 32'h0, 4'hF);
        wr(0, 0, 0, 32'h1, 4'hF);
        cycles(2);
        rchk("new_preset_used", 0, 0, 2, 32'd2);
        wr(0, 0, 0, 32'h0, 4'hF);

        // 4x8 instance: width truncation, byteen on CTRL, PRESET=0 latency
        wr(1, 3, 1, 32'h1FF, 4'hF);
        rchk("b_preset_trunc", 1, 3, 1, 32'hFF);
        wr(1, 3, 0, 32'hF, 4'b1110);
        rchk("b_ctrl_be", 1, 3, 0, 32'h0);
        wr(1, 2, 1, 32'h0, 4'hF);
        wr(1, 2, 0, 32'h9, 4'hF);
        cycles(2);
        chk("b_p0_early", 32'(irq_b), 32'h0);
        cycles(1);
        chk("b_p0_irq", 32'(irq_b), 32'h4);
        chk("b_p0_any", 32'(any_b), 32'h1);

        // 3x16 instance: out-of-range channel
        wr(2, 3, 1, 32'h1234, 4'hF);
        rchk("c_oor_read", 2, 3, 1, 32'h0);
        rchk("c_ch0_untouched", 2, 0, 1, 32'h0);
        wr(2, 3, 0, 32'h9, 4'hF);
        cycles(4);
        chk("c_oor_irq", 32'(irq_c), 32'h0);
        wr(2, 0, 1, 32'hABCD1234, 4'hF);
        rchk("c_width16", 2, 0, 1, 32'h1234);

        // Asynchronous reset mid-count
        wr(0, 0, 1, 32'd20, 4'hF);
        wr(0, 0, 0, 32'h1, 4'hF);
        wr(0, 1, 1, 32'h0, 4'hF);
        wr(0, 1, 0, 32'hB, 4'hF);
        cycles(3);
        chk("pre_rst_irq", 32'(irq_a), 32'h2);
        rchk("pre_rst_count", 0, 0, 2, 32'd17);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_irq", 32'(irq_a), 32'h0);
        chk("arst_any", 32'(any_a), 32'h0);
        rchk("arst_count", 0, 0, 2, 32'h0);
        rchk("arst_status", 0, 0, 3, 32'h0);
        rchk("arst_ctrl", 0, 0, 0, 32'h0);
        rchk("arst_preset", 0, 1, 1, 32'h0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
